uart_apb_sequencer: RTL and testbench



---
 rtl/uart_apb_seq_pkg.sv | 33 +++
 rtl/apb_master_xfer.sv | 81 ++++++++
 rtl/uart_apb_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_uart_apb_sequencer.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_apb_seq_pkg.sv
// Shared types and constants for the CoreUARTapb sequencer: FSM states,
// UART register offsets and STATUS bit positions.
package uart_apb_seq_pkg;

   typedef enum logic [2:0] {
      ST_CFG1   = 3'd0,
      ST_CFG2   = 3'd1,
      ST_POLL   = 3'd2,
      ST_DECIDE = 3'd3,
      ST_RDRX   = 3'd4,
      ST_WRTX   = 3'd5,
      ST_GAP    = 3'd6
   } seq_state_e;

   localparam logic [4:0] ADDR_TXDATA = 5'h00;
   localparam logic [4:0] ADDR_RXDATA = 5'h04;
   localparam logic [4:0] ADDR_CTRL1  = 5'h08;
   localparam logic [4:0] ADDR_CTRL2  = 5'h0C;
   localparam logic [4:0] ADDR_STATUS = 5'h10;

   localparam int STS_TXRDY    = 0;
   localparam int STS_RXRDY    = 1;
   localparam int STS_PARITY   = 2;
   localparam int STS_OVERFLOW = 3;
   localparam int STS_FRAMING  = 4;

   function automatic logic [7:0] ctrl2_value(input logic [12:0] baud,
                                              input logic        bit8,
                                              input logic [1:0]  parity);
      return {baud[12:8], parity[1], parity[0], bit8};
   endfunction

endpackage

// File: rtl/apb_master_xfer.sv
// Single-transfer APB master engine: SETUP then ACCESS until PREADY.
// A new start accepted on the completing cycle chains straight into SETUP.
module apb_master_xfer
   import uart_apb_seq_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_i,
   input  logic       write_i,
   input  logic [4:0] addr_i,
   input  logic [7:0] wdata_i,
   output logic       done_o,
   output logic [7:0] rdata_o,
   output logic       slverr_o,
   output logic [4:0] paddr_o,
   output logic       psel_o,
   output logic       penable_o,
   output logic       pwrite_o,
   output logic [7:0] pwdata_o,
   input  logic [7:0] prdata_i,
   input  logic       pready_i,
   input  logic       pslverr_i
);

   logic       psel_q, psel_d;
   logic       penable_q, penable_d;
   logic       pwrite_q, pwrite_d;
   logic [4:0] paddr_q, paddr_d;
   logic [7:0] pwdata_q, pwdata_d;
   logic       done_s;

   assign done_s = psel_q & penable_q & pready_i;

   always_comb begin
      psel_d    = psel_q;
      penable_d = penable_q;
      pwrite_d  = pwrite_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      if (start_i && (!psel_q || done_s)) begin
         psel_d    = 1'b1;
         penable_d = 1'b0;
         pwrite_d  = write_i;
         paddr_d   = addr_i;
         pwdata_d  = wdata_i;
      end else if (psel_q && !penable_q) begin
         penable_d = 1'b1;
      end else if (done_s) begin
         psel_d    = 1'b0;
         penable_d = 1'b0;
      end else begin
         psel_d    = psel_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= 5'h00;
         pwdata_q  <= 8'h00;
      end else begin
         psel_q    <= psel_d;
         penable_q <= penable_d;
         pwrite_q  <= pwrite_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
      end
   end

   assign done_o    = done_s;
   assign rdata_o   = prdata_i;
   assign slverr_o  = pslverr_i;
   assign psel_o    = psel_q;
   assign penable_o = penable_q;
   assign pwrite_o  = pwrite_q;
   assign paddr_o   = paddr_q;
   assign pwdata_o  = pwdata_q;

endmodule

// File: rtl/uart_apb_sequencer.sv
// APB master that configures a CoreUARTapb, then polls STATUS and moves
// bytes between the UART and TX/RX valid/ready streams with sticky errors.
module uart_apb_sequencer
   import uart_apb_seq_pkg::*;
#(
   parameter logic [12:0] BAUD_VALUE = 13'd1,
   parameter logic        PRG_BIT8   = 1'b1,
   parameter logic [1:0]  PRG_PARITY = 2'b00,
   parameter int unsigned POLL_GAP   = 4
) (
   input  logic       PCLK,
   input  logic       PRESETN,
   output logic [4:0] PADDR,
   output logic       PSEL,
   output logic       PENABLE,
   output logic       PWRITE,
   output logic [7:0] PWDATA,
   input  logic [7:0] PRDATA,
   input  logic       PREADY,
   input  logic       PSLVERR,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       init_done,
   output logic [3:0] err_flags,
   input  logic       err_clr
);

   localparam logic [7:0] GAP_LOAD = (POLL_GAP > 0) ? 8'(POLL_GAP - 1) : 8'd0;

   seq_state_e state_q, state_d;
   logic [1:0] rdy_q, rdy_d;
   logic       last_tx_q, last_tx_d;
   logic [7:0] gap_q, gap_d;
   logic       init_done_q, init_done_d;
   logic       tx_ready_q, tx_ready_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic [3:0] err_q, err_d;

   logic       rx_elig_s, tx_elig_s, poll_done_s;
   logic       req_s, start_s, write_s;
   logic [4:0] addr_s;
   logic [7:0] wdata_s;
   logic       xfer_done_s, xfer_slverr_s;
   logic [7:0] xfer_rdata_s;

   always_comb begin
      state_d     = state_q;
      rdy_d       = rdy_q;
      last_tx_d   = last_tx_q;
      gap_d       = gap_q;
      init_done_d = init_done_q;
      rx_elig_s   = rdy_q[STS_RXRDY] && (!rx_valid_q || rx_ready);
      tx_elig_s   = rdy_q[STS_TXRDY] && tx_valid;
      case (state_q)
         ST_CFG1: if (xfer_done_s) state_d = ST_CFG2; else state_d = state_q;
         ST_CFG2: begin
            if (xfer_done_s) begin
               state_d     = ST_POLL;
               init_done_d = 1'b1;
            end else begin
               state_d     = state_q;
            end
         end
         ST_POLL: begin
            if (xfer_done_s) begin
               state_d = ST_DECIDE;
               rdy_d   = {xfer_rdata_s[STS_RXRDY], xfer_rdata_s[STS_TXRDY]};
            end else begin
               state_d = state_q;
            end
         end
         // Ties go to whichever side was not served last.
         ST_DECIDE: begin
            if (rx_elig_s && (!tx_elig_s || last_tx_q)) begin
               state_d   = ST_RDRX;
               last_tx_d = 1'b0;
            end else if (tx_elig_s) begin
               state_d   = ST_WRTX;
               last_tx_d = 1'b1;
            end else if (POLL_GAP == 0) begin
               state_d   = ST_POLL;
            end else begin
               state_d   = ST_GAP;
               gap_d     = GAP_LOAD;
            end
         end
         ST_RDRX: if (xfer_done_s) state_d = ST_POLL; else state_d = state_q;
         ST_WRTX: if (xfer_done_s) state_d = ST_POLL; else state_d = state_q;
         ST_GAP: begin
            if (gap_q == 8'd0) state_d = ST_POLL;
            else gap_d = gap_q - 8'd1;
         end
         default: state_d = ST_CFG1;
      endcase
   end

   // Transfers are launched from the upcoming state so consecutive accesses chain without idle cycles.
   always_comb begin
      req_s   = 1'b0;
      write_s = 1'b0;
      addr_s  = ADDR_STATUS;
      wdata_s = 8'h00;
      case (state_d)
         ST_CFG1: begin req_s = 1'b1; write_s = 1'b1; addr_s = ADDR_CTRL1; wdata_s = BAUD_VALUE[7:0]; end
         ST_CFG2: begin
            req_s   = 1'b1;
            write_s = 1'b1;
            addr_s  = ADDR_CTRL2;
            wdata_s = ctrl2_value(BAUD_VALUE, PRG_BIT8, PRG_PARITY);
         end
         ST_POLL: begin req_s = 1'b1; addr_s = ADDR_STATUS; end
         ST_RDRX: begin req_s = 1'b1; addr_s = ADDR_RXDATA; end
         ST_WRTX: begin req_s = 1'b1; write_s = 1'b1; addr_s = ADDR_TXDATA; wdata_s = tx_data; end
         default: req_s = 1'b0;
      endcase
      start_s    = req_s && (!PSEL || xfer_done_s);
      tx_ready_d = start_s && (state_d == ST_WRTX);
   end

   always_comb begin
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q;
      poll_done_s = xfer_done_s && (state_q == ST_POLL);
      if (xfer_done_s && (state_q == ST_RDRX)) begin
         rx_data_d  = xfer_rdata_s;
         rx_valid_d = 1'b1;
      end else if (rx_valid_q && rx_ready) begin
         rx_valid_d = 1'b0;
      end else begin
         rx_valid_d = rx_valid_q;
      end
      err_d = (err_clr ? 4'b0000 : err_q) |
              {xfer_done_s & xfer_slverr_s,
               poll_done_s ? {xfer_rdata_s[STS_FRAMING], xfer_rdata_s[STS_OVERFLOW],
                              xfer_rdata_s[STS_PARITY]} : 3'b000};
   end

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         state_q     <= ST_CFG1;
         rdy_q       <= 2'b00;
         last_tx_q   <= 1'b1;
         gap_q       <= 8'd0;
         init_done_q <= 1'b0;
         tx_ready_q  <= 1'b0;
         rx_data_q   <= 8'h00;
         rx_valid_q  <= 1'b0;
         err_q       <= 4'b0000;
      end else begin
         state_q     <= state_d;
         rdy_q       <= rdy_d;
         last_tx_q   <= last_tx_d;
         gap_q       <= gap_d;
         init_done_q <= init_done_d;
         tx_ready_q  <= tx_ready_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         err_q       <= err_d;
      end
   end

   apb_master_xfer u_xfer (
      .clk       (PCLK),
      .rst_n     (PRESETN),
      .start_i   (start_s),
      .write_i   (write_s),
      .addr_i    (addr_s),
      .wdata_i   (wdata_s),
      .done_o    (xfer_done_s),
      .rdata_o   (xfer_rdata_s),
      .slverr_o  (xfer_slverr_s),
      .paddr_o   (PADDR),
      .psel_o    (PSEL),
      .penable_o (PENABLE),
      .pwrite_o  (PWRITE),
      .pwdata_o  (PWDATA),
      .prdata_i  (PRDATA),
      .pready_i  (PREADY),
      .pslverr_i (PSLVERR)
   );

   assign tx_ready  = tx_ready_q;
   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign init_done = init_done_q;
   assign err_flags = err_q;

endmodule

// File: tb/tb_uart_apb_sequencer.sv
// Directed bench for uart_apb_sequencer with a behavioural CoreUARTapb slave
// answering STATUS/RXDATA reads and a monitor logging completed transfers.
module tb_uart_apb_sequencer;

   logic       PCLK = 1'b0;
   logic       PRESETN = 1'b0;
   logic [4:0] PADDR;
   logic       PSEL, PENABLE, PWRITE;
   logic [7:0] PWDATA, PRDATA;
   logic       PREADY, PSLVERR;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready = 1'b0;
   logic       init_done;
   logic [3:0] err_flags;
   logic       err_clr = 1'b0;

   logic [7:0] status_v = 8'h00;
   logic [7:0] rxd_v = 8'h00;
   logic       pready_v = 1'b1;
   logic       pslverr_v = 1'b0;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [4:0] addr;
      logic       wr;
      logic [7:0] wdata;
   } xfer_t;
   xfer_t xq[$];

   uart_apb_sequencer #(
      .BAUD_VALUE (13'h123),
      .PRG_BIT8   (1'b1),
      .PRG_PARITY (2'b11),
      .POLL_GAP   (2)
   ) dut (
      .PCLK(PCLK), .PRESETN(PRESETN), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .init_done(init_done), .err_flags(err_flags), .err_clr(err_clr)
   );

   always #5 PCLK = ~PCLK;

   assign PRDATA  = (PADDR == 5'h10) ? status_v : ((PADDR == 5'h04) ? rxd_v : 8'h00);
   assign PREADY  = pready_v;
   assign PSLVERR = pslverr_v;

   always @(negedge PCLK) begin
      if (PRESETN && PSEL && PENABLE && PREADY)
         xq.push_back('{addr: PADDR, wr: PWRITE, wdata: PWDATA});
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge PCLK);
         #1;
      end
   endtask

   // Waits (at negedge) for a completing access phase; any address if match_addr is 0.
   task automatic wait_access(input logic [4:0] addr, input logic match_addr, input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge PCLK);
         if (PSEL && PENABLE && PREADY && (!match_addr || PADDR == addr)) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got timeout expected completed access", name);
      end
   endtask

   task automatic do_reset();
      PRESETN = 1'b0;
      tick(2);
      PRESETN = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (init_done) break;
      end
      checks++;
      if (init_done !== 1'b1) begin
         errors++;
         $display("FAIL reset_init: got init_done=%b expected 1", init_done);
      end
   endtask

   task automatic test_reset();
      PRESETN = 1'b0;
      tick(3);
      checks++;
      if ({PSEL, PENABLE, PWRITE, tx_ready, rx_valid, init_done, PADDR, PWDATA, rx_data, err_flags} !== 33'd0) begin
         errors++;
         $display("FAIL reset_values: got psel=%b pen=%b pw=%b txr=%b rxv=%b idone=%b paddr=%h pwdata=%h rxd=%h err=%b expected all 0",
                  PSEL, PENABLE, PWRITE, tx_ready, rx_valid, init_done, PADDR, PWDATA, rx_data, err_flags);
      end
      PRESETN = 1'b1;
      tick(1);
      checks++;
      if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {3'b101, 5'h08, 8'h23}) begin
         errors++;
         $display("FAIL cfg1_setup: got sel/en/wr=%b%b%b addr=%h data=%h expected 101 08 23", PSEL, PENABLE, PWRITE, PADDR, PWDATA);
      end
      tick(1);
      checks++;
      if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {3'b111, 5'h08, 8'h23}) begin
         errors++;
         $display("FAIL cfg1_access: got sel/en/wr=%b%b%b addr=%h data=%h expected 111 08 23", PSEL, PENABLE, PWRITE, PADDR, PWDATA);
      end
      tick(1);
      checks++;
      if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, init_done} !== {3'b101, 5'h0C, 8'h0F, 1'b0}) begin
         errors++;
         $display("FAIL cfg2_setup: got sel/en/wr=%b%b%b addr=%h data=%h idone=%b expected 101 0c 0f 0", PSEL, PENABLE, PWRITE, PADDR, PWDATA, init_done);
      end
      tick(1);
      checks++;
      if ({PSEL, PENABLE, PADDR, init_done} !== {2'b11, 5'h0C, 1'b0}) begin
         errors++;
         $display("FAIL cfg2_access: got sel/en=%b%b addr=%h idone=%b expected 11 0c 0", PSEL, PENABLE, PADDR, init_done);
      end
      tick(1);
      checks++;
      if ({init_done, PSEL, PENABLE, PWRITE, PADDR} !== {4'b1100, 5'h10}) begin
         errors++;
         $display("FAIL init_done_c5: got idone=%b sel/en/wr=%b%b%b addr=%h expected 1 100 10", init_done, PSEL, PENABLE, PWRITE, PADDR);
      end
   endtask

   task automatic test_tx();
      int seen = 0;
      int nwr = 0;
      int idx = -1;
      bit drop = 1'b0;
      logic [9:0] setup_snap = 10'h0;
      xq.delete();
      tx_data = 8'hA5;
      tx_valid = 1'b1;
      status_v = 8'h01;
      for (int i = 0; i < 40; i++) begin
         tick(1);
         if (tx_ready) begin
            seen++;
            setup_snap = {PSEL, PENABLE, PADDR[4:2], PWDATA[4:0]};
            drop = 1'b1;
         end else if (drop) begin
            tx_valid = 1'b0;
            drop = 1'b0;
         end
      end
      checks++;
      if (seen != 1) begin
         errors++;
         $display("FAIL tx_ready_pulse: got %0d cycles expected 1", seen);
      end
      checks++;
      if (setup_snap !== {2'b10, 3'b000, 5'h05}) begin
         errors++;
         $display("FAIL tx_setup_phase: got %h expected %h", setup_snap, {2'b10, 3'b000, 5'h05});
      end
      foreach (xq[k]) if (xq[k].addr == 5'h00 && xq[k].wr) begin nwr++; if (idx < 0) idx = k; end
      checks++;
      if (nwr != 1 || idx < 0 || xq[idx].wdata !== 8'hA5) begin
         errors++;
         $display("FAIL tx_write: got %0d writes data=%h expected 1 write of a5", nwr, (idx >= 0) ? xq[idx].wdata : 8'h00);
      end
      checks++;
      if (idx < 0 || idx + 1 >= xq.size() || xq[idx+1].addr !== 5'h10 || xq[idx+1].wr !== 1'b0) begin
         errors++;
         $display("FAIL tx_then_poll: got next=%h expected read 10", (idx >= 0 && idx + 1 < xq.size()) ? xq[idx+1].addr : 5'h1F);
      end
      xq.delete();
      tick(40);
      nwr = 0;
      foreach (xq[k]) if (xq[k].addr == 5'h00) nwr++;
      checks++;
      if (nwr != 0 || xq.size() < 2) begin
         errors++;
         $display("FAIL tx_idle: got %0d tx writes of %0d xfers expected 0 writes with polling", nwr, xq.size());
      end
   endtask

   task automatic test_rx();
      int nrd = 0;
      status_v = 8'h02;
      rxd_v = 8'h3C;
      rx_ready = 1'b0;
      for (int i = 0; i < 60; i++) begin tick(1); if (rx_valid) break; end
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== 8'h3C) begin
         errors++;
         $display("FAIL rx_first: got valid=%b data=%h expected 1 3c", rx_valid, rx_data);
      end
      rxd_v = 8'h55;
      xq.delete();
      tick(40);
      foreach (xq[k]) if (xq[k].addr == 5'h04) nrd++;
      checks++;
      if (nrd != 0 || rx_valid !== 1'b1 || rx_data !== 8'h3C || xq.size() < 2) begin
         errors++;
         $display("FAIL rx_hold: got reads=%0d valid=%b data=%h polls=%0d expected 0 1 3c >=2", nrd, rx_valid, rx_data, xq.size());
      end
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
      checks++;
      if (rx_valid !== 1'b0) begin
         errors++;
         $display("FAIL rx_consume: got valid=%b expected 0", rx_valid);
      end
      for (int i = 0; i < 60; i++) begin tick(1); if (rx_valid) break; end
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== 8'h55) begin
         errors++;
         $display("FAIL rx_second: got valid=%b data=%h expected 1 55", rx_valid, rx_data);
      end
      status_v = 8'h00;
      rx_ready = 1'b1;
      tick(2);
   endtask

   task automatic test_back_to_back();
      logic [4:0] seq[$];
      logic [4:0] exp_addr;
      status_v = 8'h03;
      rxd_v = 8'h77;
      tx_data = 8'h5A;
      tx_valid = 1'b1;
      rx_ready = 1'b1;
      do_reset();
      xq.delete();
      tick(80);
      foreach (xq[k]) if (xq[k].addr == 5'h00 || xq[k].addr == 5'h04) seq.push_back(xq[k].addr);
      checks++;
      if (seq.size() < 6) begin
         errors++;
         $display("FAIL alt_count: got %0d data xfers expected >= 6", seq.size());
      end
      for (int k = 0; k < 6 && k < seq.size(); k++) begin
         exp_addr = (k % 2 == 0) ? 5'h04 : 5'h00;
         checks++;
         if (seq[k] !== exp_addr) begin
            errors++;
            $display("FAIL alt_order[%0d]: got %h expected %h", k, seq[k], exp_addr);
         end
      end
      tx_valid = 1'b0;
      status_v = 8'h00;
      tick(6);
   endtask

   task automatic test_errors();
      checks++;
      if (err_flags !== 4'b0000) begin
         errors++;
         $display("FAIL err_initial: got %b expected 0000", err_flags);
      end
      status_v = 8'h1C;
      wait_access(5'h10, 1'b1, "err_poll_1c");
      @(posedge PCLK); #1;
      status_v = 8'h00;
      tick(1);
      checks++;
      if (err_flags !== 4'b0111) begin
         errors++;
         $display("FAIL err_sticky: got %b expected 0111", err_flags);
      end
      status_v = 8'h04;
      wait_access(5'h10, 1'b1, "err_poll_04");
      err_clr = 1'b1;
      @(posedge PCLK); #1;
      err_clr = 1'b0;
      status_v = 8'h00;
      checks++;
      if (err_flags !== 4'b0001) begin
         errors++;
         $display("FAIL err_clr_set_wins: got %b expected 0001", err_flags);
      end
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      checks++;
      if (err_flags !== 4'b0000) begin
         errors++;
         $display("FAIL err_clear: got %b expected 0000", err_flags);
      end
      pslverr_v = 1'b1;
      wait_access(5'h00, 1'b0, "err_slverr_xfer");
      @(posedge PCLK); #1;
      pslverr_v = 1'b0;
      checks++;
      if (err_flags !== 4'b1000) begin
         errors++;
         $display("FAIL err_slverr: got %b expected 1000", err_flags);
      end
   endtask

   task automatic test_wait_reset();
      PRESETN = 1'b0;
      pready_v = 1'b0;
      tick(2);
      PRESETN = 1'b1;
      tick(1);
      checks++;
      if ({PSEL, PENABLE, PADDR} !== {2'b10, 5'h08}) begin
         errors++;
         $display("FAIL ws_setup: got sel/en=%b%b addr=%h expected 10 08", PSEL, PENABLE, PADDR);
      end
      for (int k = 0; k < 3; k++) begin
         tick(1);
         checks++;
         if ({PSEL, PENABLE, PADDR, init_done} !== {2'b11, 5'h08, 1'b0}) begin
            errors++;
            $display("FAIL ws_hold[%0d]: got sel/en=%b%b addr=%h idone=%b expected 11 08 0", k, PSEL, PENABLE, PADDR, init_done);
         end
      end
      #3;
      PRESETN = 1'b0;
      #1;
      checks++;
      if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, init_done} !== 17'd0) begin
         errors++;
         $display("FAIL async_abort: got sel/en/wr=%b%b%b addr=%h data=%h idone=%b expected all 0", PSEL, PENABLE, PWRITE, PADDR, PWDATA, init_done);
      end
      pready_v = 1'b1;
      @(posedge PCLK); #1;
      PRESETN = 1'b1;
      tick(1);
      checks++;
      if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {3'b101, 5'h08, 8'h23}) begin
         errors++;
         $display("FAIL cfg_restart: got sel/en/wr=%b%b%b addr=%h data=%h expected 101 08 23", PSEL, PENABLE, PWRITE, PADDR, PWDATA);
      end
      tick(4);
      checks++;
      if (init_done !== 1'b1) begin
         errors++;
         $display("FAIL cfg_restart_done: got %b expected 1", init_done);
      end
   endtask

   initial begin
      test_reset();
      test_tx();
      test_rx();
      test_back_to_back();
      test_errors();
      test_wait_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
